// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher feeding a 1:4 demux: accepts one bit at a time and
// holds data/channel on i/s for HOLD_CYCLES cycles on the next enabled channel.
//
// state     | meaning
// ST_IDLE   | waiting for a bit; i = 0, s keeps the last dispatched channel
// ST_DRIVE  | latched bit on i, latched channel on s, hold counter running
module demux_rr_dispatcher #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic [3:0]       ch_en,
    output logic             i,
    output logic [1:0]       s,
    output logic             busy,
    output logic [CNT_W-1:0] disp_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] hold_q;
    logic [1:0] last_ch_q;
    logic [1:0] target;
    logic [1:0] cand;
    logic       found;
    logic       accept;

    // rst_n gates in_ready so nothing is offered or accepted while held in reset
    assign in_ready = rst_n && (state_q == ST_IDLE) && (ch_en != 4'b0000);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == ST_DRIVE);

    always_comb begin
        target = last_ch_q;
        cand   = last_ch_q;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_ch_q + 2'(k);
            if (!found && ch_en[cand]) begin
                target = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_DRIVE;
            ST_DRIVE: if (hold_q == 8'd0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i         <= 1'b0;
            s         <= 2'b00;
            last_ch_q <= 2'd3;
            hold_q    <= 8'd0;
            disp_cnt  <= '0;
        end else if (accept) begin
            i         <= in_bit;
            s         <= target;
            last_ch_q <= target;
            hold_q    <= HOLD_LOAD;
            disp_cnt  <= disp_cnt + CNT_W'(1);
        end else if (state_q == ST_DRIVE) begin
            // s is left alone on the way out so the demux only sees i fall
            if (hold_q == 8'd0) begin
                i <= 1'b0;
            end else begin
                hold_q <= hold_q - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: two instances (hold 2 / 3-bit count, hold 4 /
// 16-bit count) compared every cycle against a per-instance behavioural model.
module tb_demux_rr_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, v_a, b_a, rdy_a, i_a, busy_a;
    logic [3:0]  en_a;
    logic [1:0]  s_a;
    logic [2:0]  cnt_a;
    logic        rst_n_b, v_b, b_b, rdy_b, i_b, busy_b;
    logic [3:0]  en_b;
    logic [1:0]  s_b;
    logic [15:0] cnt_b;

    demux_rr_dispatcher #(.HOLD_CYCLES(2), .CNT_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .in_valid(v_a), .in_bit(b_a), .in_ready(rdy_a),
        .ch_en(en_a), .i(i_a), .s(s_a), .busy(busy_a), .disp_cnt(cnt_a));

    demux_rr_dispatcher #(.HOLD_CYCLES(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(v_b), .in_bit(b_b), .in_ready(rdy_b),
        .ch_en(en_b), .i(i_b), .s(s_b), .busy(busy_b), .disp_cnt(cnt_b));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // shadow of driven inputs
    logic       brst[2];
    logic       bv[2];
    logic       bb[2];
    logic [3:0] ben[2];

    // reference model: cycles left on the output, shown bit/channel, rotation pointer, total accepts
    int m_left[2];
    int m_bit[2];
    int m_ch[2];
    int m_last[2];
    int m_cnt[2];
    int hold[2]  = '{2, 4};
    int cmask[2] = '{7, 65535};
    bit acc[2];

    task automatic chk(input string tag, input int x, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst%0d observed %0h expected %0h", tag, x, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_rdy(input int x);
        return (x == 0) ? 32'(rdy_a) : 32'(rdy_b);
    endfunction
    function automatic logic [31:0] rd_i(input int x);
        return (x == 0) ? 32'(i_a) : 32'(i_b);
    endfunction
    function automatic logic [31:0] rd_s(input int x);
        return (x == 0) ? 32'(s_a) : 32'(s_b);
    endfunction
    function automatic logic [31:0] rd_busy(input int x);
        return (x == 0) ? 32'(busy_a) : 32'(busy_b);
    endfunction
    function automatic logic [31:0] rd_cnt(input int x);
        return (x == 0) ? 32'(cnt_a) : 32'(cnt_b);
    endfunction

    task automatic set_in(input int x, input logic nv, input logic nb, input logic [3:0] ne);
        bv[x] = nv; bb[x] = nb; ben[x] = ne;
        if (x == 0) begin v_a = nv; b_a = nb; en_a = ne; end
        else        begin v_b = nv; b_b = nb; en_b = ne; end
    endtask

    task automatic set_rst(input int x, input logic r);
        brst[x] = r;
        if (x == 0) rst_n_a = r; else rst_n_b = r;
    endtask

    task automatic model_reset(input int x);
        m_left[x] = 0; m_bit[x] = 0; m_ch[x] = 0; m_last[x] = 3; m_cnt[x] = 0;
    endtask

    task automatic check_out(input int x);
        chk("i",        x, rd_i(x),    32'((m_left[x] > 0) ? m_bit[x] : 0));
        chk("s",        x, rd_s(x),    32'(m_ch[x]));
        chk("busy",     x, rd_busy(x), 32'((m_left[x] > 0) ? 1 : 0));
        chk("disp_cnt", x, rd_cnt(x),  32'(m_cnt[x] & cmask[x]));
    endtask

    task automatic cycle();
        #1;
        for (int x = 0; x < 2; x++) begin
            bit er;
            er = brst[x] && (m_left[x] == 0) && (ben[x] != 4'b0000);
            chk("in_ready", x, rd_rdy(x), 32'(er));
            acc[x] = bv[x] && er;
        end
        @(posedge clk);
        cyc++;
        for (int x = 0; x < 2; x++) begin
            if (brst[x]) begin
                if (m_left[x] > 0) begin
                    m_left[x]--;
                    if (m_left[x] == 0) m_bit[x] = 0;
                end else if (acc[x]) begin
                    bit done;
                    done = 0;
                    for (int k = 1; k <= 4; k++) begin
                        int c;
                        c = (m_last[x] + k) % 4;
                        if (!done && ben[x][c]) begin
                            m_ch[x] = c;
                            done = 1;
                        end
                    end
                    m_last[x] = m_ch[x];
                    m_bit[x]  = int'(bb[x]);
                    m_left[x] = hold[x];
                    m_cnt[x]++;
                end
            end
        end
        #1;
        for (int x = 0; x < 2; x++) check_out(x);
    endtask

    task automatic do_reset(input int x);
        set_rst(x, 1'b0);
        model_reset(x);
        #1;
        check_out(x);
        chk("in_ready_rst", x, rd_rdy(x), 32'd0);
    endtask

    task automatic send(input int x, input logic nb, input logic [3:0] ne);
        int got;
        got = 0;
        set_in(x, 1'b1, nb, ne);
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (acc[x]) begin
                got = 1;
                break;
            end
        end
        chk("accept_timeout", x, 32'(got), 32'd1);
    endtask

    initial begin
        int gap_ref;
        int exp_rr[5];
        int exp_sp[4];
        logic rr_bits[5];
        exp_rr  = '{0, 1, 2, 3, 0};
        exp_sp  = '{1, 3, 1, 3};
        rr_bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        acc = '{0, 0};

        // reset with a bit already on offer
        set_rst(0, 1'b1); set_rst(1, 1'b1);
        set_in(0, 1'b1, 1'b1, 4'b1111);
        set_in(1, 1'b0, 1'b0, 4'b1111);
        #1;
        do_reset(0);
        do_reset(1);
        cycle();
        cycle();
        set_rst(0, 1'b1); set_rst(1, 1'b1);
        cycle();
        set_in(0, 1'b0, 1'b0, 4'b1111);
        for (int k = 0; k < 3; k++) cycle();

        // round robin over all channels, back-to-back
        do_reset(0);
        set_rst(0, 1'b1);
        gap_ref = 0;
        for (int n = 0; n < 5; n++) begin
            send(0, rr_bits[n], 4'b1111);
            chk("rr_s", 0, rd_s(0), 32'(exp_rr[n]));
            chk("rr_i", 0, rd_i(0), 32'(rr_bits[n]));
            if (n > 0) chk("rr_gap", 0, 32'(cyc - gap_ref), 32'd3);
            gap_ref = cyc;
        end
        chk("rr_cnt", 0, rd_cnt(0), 32'd5);

        // sparse mask, then mask change while driving
        for (int n = 0; n < 4; n++) begin
            send(0, 1'b1, 4'b1010);
            chk("sparse_s", 0, rd_s(0), 32'(exp_sp[n]));
        end
        set_in(0, 1'b0, 1'b0, 4'b0100);
        cycle();
        chk("middrive_s", 0, rd_s(0), 32'd3);
        chk("middrive_busy", 0, rd_busy(0), 32'd1);
        send(0, 1'b1, 4'b0100);
        chk("after_mask_s", 0, rd_s(0), 32'd2);

        // empty mask stalls the source
        set_in(0, 1'b1, 1'b1, 4'b0000);
        for (int k = 0; k < 10; k++) cycle();
        chk("empty_cnt", 0, rd_cnt(0), 32'd2);
        set_in(0, 1'b1, 1'b1, 4'b0001);
        cycle();
        chk("unstall_busy", 0, rd_busy(0), 32'd1);
        chk("unstall_s", 0, rd_s(0), 32'd0);
        set_in(0, 1'b0, 1'b0, 4'b0001);
        for (int k = 0; k < 3; k++) cycle();

        // asynchronous reset in the second drive cycle (hold 4)
        send(1, 1'b1, 4'b0100);
        set_in(1, 1'b0, 1'b0, 4'b0100);
        cycle();
        chk("pre_rst_s", 1, rd_s(1), 32'd2);
        chk("pre_rst_i", 1, rd_i(1), 32'd1);
        do_reset(1);
        chk("rst_async_busy", 1, rd_busy(1), 32'd0);
        set_rst(1, 1'b1);
        send(1, 1'b1, 4'b1111);
        chk("post_rst_s", 1, rd_s(1), 32'd0);

        // randomized traffic on both instances
        for (int n = 0; n < 400; n++) begin
            for (int x = 0; x < 2; x++) begin
                logic nv;
                logic nb;
                logic [3:0] ne;
                nv = bv[x]; nb = bb[x]; ne = ben[x];
                if (acc[x]) nv = 1'b0;
                if (!nv && ($urandom_range(0, 1) == 1)) begin
                    nv = 1'b1;
                    nb = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 7) == 0) ne = 4'($urandom_range(0, 15));
                set_in(x, nv, nb, ne);
            end
            cycle();
        end
        set_in(0, 1'b0, 1'b0, 4'b1111);
        set_in(1, 1'b0, 1'b0, 4'b1111);
        for (int k = 0; k < 6; k++) cycle();

        // 3-bit counter wrap
        do_reset(0);
        set_rst(0, 1'b1);
        for (int n = 1; n <= 9; n++) begin
            send(0, 1'($urandom_range(0, 1)), 4'b1111);
            if (n == 7) chk("wrap7", 0, rd_cnt(0), 32'd7);
            if (n == 8) chk("wrap8", 0, rd_cnt(0), 32'd0);
            if (n == 9) chk("wrap9", 0, rd_cnt(0), 32'd1);
        end
        set_in(0, 1'b0, 1'b0, 4'b1111);
        for (int k = 0; k < 4; k++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
